// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/stall sequencer
package hazard_pkg;

  localparam int CNT_W_DEFAULT = 16;

  // ID_PCSrc encoding for jr, which reads Rs only
  localparam logic [1:0] PCSRC_JR = 2'b10;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HAZ     = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle of the hazard sequencer
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_Branch;
  logic [1:0]       ID_PCSrc;
  logic             ID_Taken;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [4:0]       EX_WriteReg;
  logic             MEM_MemRead;
  logic [4:0]       MEM_WriteReg;
  logic             MEM_MemReq;
  logic             MEM_Ready;
  logic             perf_clear;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             EX_MEM_Write;
  logic             MEM_WB_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic [CNT_W-1:0] stall_cycles;

  // pipeline side: drives stage fields, receives enables/flushes
  modport master (
    output ID_Rs, ID_Rt, ID_Branch, ID_PCSrc, ID_Taken,
    output EX_MemRead, EX_RegWrite, EX_WriteReg,
    output MEM_MemRead, MEM_WriteReg, MEM_MemReq, MEM_Ready, perf_clear,
    input  PC_Write, IF_ID_Write, EX_MEM_Write, MEM_WB_Write,
    input  IF_ID_Flush, ID_EX_Flush, stall_cycles
  );

  // hazard sequencer side
  modport slave (
    input  ID_Rs, ID_Rt, ID_Branch, ID_PCSrc, ID_Taken,
    input  EX_MemRead, EX_RegWrite, EX_WriteReg,
    input  MEM_MemRead, MEM_WriteReg, MEM_MemReq, MEM_Ready, perf_clear,
    output PC_Write, IF_ID_Write, EX_MEM_Write, MEM_WB_Write,
    output IF_ID_Flush, ID_EX_Flush, stall_cycles
  );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational stall-count detector for non-forwardable hazards
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_branch_i,
  input  logic [1:0] id_pcsrc_i,
  input  logic       ex_memread_i,
  input  logic       ex_regwrite_i,
  input  logic [4:0] ex_writereg_i,
  input  logic       mem_memread_i,
  input  logic [4:0] mem_writereg_i,
  output logic [1:0] n_o
);

  logic brjr;
  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic br_ex, br_mem;

  // $0 is hardwired, so a zero destination never matches
  assign brjr   = id_branch_i | (id_pcsrc_i == PCSRC_JR);
  assign ex_rs  = (ex_writereg_i != 5'd0) && (ex_writereg_i == id_rs_i);
  assign ex_rt  = (ex_writereg_i != 5'd0) && (ex_writereg_i == id_rt_i);
  assign mem_rs = (mem_writereg_i != 5'd0) && (mem_writereg_i == id_rs_i);
  assign mem_rt = (mem_writereg_i != 5'd0) && (mem_writereg_i == id_rt_i);

  // jr reads Rs only; conditional branches read both
  assign br_ex  = ex_rs | (id_branch_i & ex_rt);
  assign br_mem = mem_rs | (id_branch_i & mem_rt);

  // branches resolve in ID so they wait for EX/MEM results; others only for loads
  always_comb begin
    n_o = 2'd0;
    if (brjr) begin
      if (br_ex && ex_memread_i)
        n_o = 2'd2;
      else if ((br_ex && ex_regwrite_i) || (br_mem && mem_memread_i))
        n_o = 2'd1;
    end else if ((ex_rs || ex_rt) && ex_memread_i) begin
      n_o = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall sequencer FSM, pipeline enable decode and stall counter
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  state_e           state_q, state_d, mode;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [1:0]       n;
  logic             freeze;
  logic             stall;
  logic             pc_write;

  hazard_detect u_detect (
    .id_rs_i        (bus.ID_Rs),
    .id_rt_i        (bus.ID_Rt),
    .id_branch_i    (bus.ID_Branch),
    .id_pcsrc_i     (bus.ID_PCSrc),
    .ex_memread_i   (bus.EX_MemRead),
    .ex_regwrite_i  (bus.EX_RegWrite),
    .ex_writereg_i  (bus.EX_WriteReg),
    .mem_memread_i  (bus.MEM_MemRead),
    .mem_writereg_i (bus.MEM_WriteReg),
    .n_o            (n)
  );

  assign freeze = bus.MEM_MemReq & ~bus.MEM_Ready;

  // state and pending-stall count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state; the MEMWAIT exit cycle behaves as HAZ or RUN so a k-cycle
  // memory wait extends a pending hazard stall by exactly k cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    mode    = state_q;
    if (state_q == MEMWAIT)
      mode = (cnt_q != 2'd0) ? HAZ : RUN;
    if (freeze) begin
      state_d = MEMWAIT;
    end else begin
      case (mode)
        RUN: begin
          state_d = RUN;
          if (n == 2'd2) begin
            stall   = 1'b1;
            cnt_d   = 2'd1;
            state_d = HAZ;
          end else if (n == 2'd1) begin
            stall = 1'b1;
          end
        end
        HAZ: begin
          stall   = 1'b1;
          cnt_d   = cnt_q - 2'd1;
          state_d = (cnt_q == 2'd1) ? RUN : HAZ;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // enable/flush decode; reset forces the pipeline to run freely
  always_comb begin
    pc_write          = 1'b1;
    bus.IF_ID_Write   = 1'b1;
    bus.EX_MEM_Write  = 1'b1;
    bus.MEM_WB_Write  = 1'b1;
    bus.IF_ID_Flush   = 1'b0;
    bus.ID_EX_Flush   = 1'b0;
    if (!reset) begin
      if (freeze) begin
        pc_write         = 1'b0;
        bus.IF_ID_Write  = 1'b0;
        bus.EX_MEM_Write = 1'b0;
        bus.MEM_WB_Write = 1'b0;
      end else if (stall) begin
        pc_write         = 1'b0;
        bus.IF_ID_Write  = 1'b0;
        bus.ID_EX_Flush  = 1'b1;
      end else begin
        bus.IF_ID_Flush  = bus.ID_Taken;
      end
    end
  end

  assign bus.PC_Write = pc_write;

  // saturating count of cycles with PC held; clear wins over increment
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (bus.perf_clear)
      stall_cycles_d = '0;
    else if (!pc_write && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  // stall-cycle counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles_q <= '0;
    else
      stall_cycles_q <= stall_cycles_d;
  end

  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 16;

  // {PC_Write, IF_ID_Write, EX_MEM_Write, MEM_WB_Write, IF_ID_Flush, ID_EX_Flush}
  localparam logic [5:0] NORM    = 6'b111100;
  localparam logic [5:0] NORM_TK = 6'b111110;
  localparam logic [5:0] STALL   = 6'b001101;
  localparam logic [5:0] FRZ     = 6'b000000;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [5:0] outs;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign outs = {bus.PC_Write, bus.IF_ID_Write, bus.EX_MEM_Write,
                 bus.MEM_WB_Write, bus.IF_ID_Flush, bus.ID_EX_Flush};

  task automatic clr_inputs();
    bus.ID_Rs = 5'd0; bus.ID_Rt = 5'd0; bus.ID_Branch = 1'b0;
    bus.ID_PCSrc = 2'b00; bus.ID_Taken = 1'b0;
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WriteReg = 5'd0;
    bus.MEM_MemRead = 1'b0; bus.MEM_WriteReg = 5'd0;
    bus.MEM_MemReq = 1'b0; bus.MEM_Ready = 1'b0; bus.perf_clear = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    clr_inputs();
    bus.perf_clear = 1'b1;
    next_cycle();
    bus.perf_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_inputs();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd1;
    bus.ID_Rs = 5'd1; bus.MEM_MemReq = 1'b1; bus.ID_Taken = 1'b1;
    #2;
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL rst_outs: got %b expected %b", outs, NORM);
    end
    checks++;
    if (bus.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL rst_perf: got %0d expected 0", bus.stall_cycles);
    end
    next_cycle();
    reset = 1'b0;
    clr_inputs();
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL rst_release: got %b expected %b", outs, NORM);
    end
  endtask

  task automatic test_load_use();
    start_test();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd1;
    bus.ID_Rs = 5'd1; bus.ID_Rt = 5'd5;
    @(negedge clk);
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL lu_stall: got %b expected %b", outs, STALL);
    end
    next_cycle();
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WriteReg = 5'd0;
    bus.MEM_MemRead = 1'b1; bus.MEM_WriteReg = 5'd1;
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL lu_release: got %b expected %b", outs, NORM);
    end
    next_cycle();
    checks++;
    if (bus.stall_cycles !== 16'd1) begin
      errors++; $display("FAIL lu_perf: got %0d expected 1", bus.stall_cycles);
    end
    // load feeding Rt of a non-branch also stalls
    clr_inputs();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd7;
    bus.ID_Rs = 5'd2; bus.ID_Rt = 5'd7;
    @(negedge clk);
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL lu_rt: got %b expected %b", outs, STALL);
    end
    next_cycle();
    clr_inputs();
  endtask

  task automatic test_no_hazard();
    start_test();
    // ALU producer to a non-branch is forwarded, no stall
    bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd4; bus.ID_Rs = 5'd4;
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL nh_alu: got %b expected %b", outs, NORM);
    end
    next_cycle();
    // load to $0
    clr_inputs();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL nh_r0: got %b expected %b", outs, NORM);
    end
    next_cycle();
    // jr ignores an Rt match
    clr_inputs();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd4;
    bus.ID_PCSrc = PCSRC_JR; bus.ID_Rs = 5'd3; bus.ID_Rt = 5'd4;
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL nh_jr_rt: got %b expected %b", outs, NORM);
    end
    next_cycle();
    clr_inputs();
  endtask

  task automatic test_branch_load();
    start_test();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd1;
    bus.ID_Branch = 1'b1; bus.ID_Rs = 5'd1; bus.ID_Rt = 5'd2; bus.ID_Taken = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL bl_stall1: got %b expected %b", outs, STALL);
    end
    next_cycle();
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WriteReg = 5'd0;
    bus.MEM_MemRead = 1'b1; bus.MEM_WriteReg = 5'd1;
    @(negedge clk);
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL bl_stall2: got %b expected %b", outs, STALL);
    end
    next_cycle();
    bus.MEM_MemRead = 1'b0; bus.MEM_WriteReg = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== NORM_TK) begin
      errors++; $display("FAIL bl_release: got %b expected %b", outs, NORM_TK);
    end
    next_cycle();
    checks++;
    if (bus.stall_cycles !== 16'd2) begin
      errors++; $display("FAIL bl_perf: got %0d expected 2", bus.stall_cycles);
    end
    clr_inputs();
  endtask

  task automatic test_jr();
    start_test();
    bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd3;
    bus.ID_PCSrc = PCSRC_JR; bus.ID_Rs = 5'd3;
    @(negedge clk);
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL jr_stall: got %b expected %b", outs, STALL);
    end
    next_cycle();
    bus.EX_RegWrite = 1'b0; bus.EX_WriteReg = 5'd0; bus.MEM_WriteReg = 5'd3;
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL jr_release: got %b expected %b", outs, NORM);
    end
    next_cycle();
    checks++;
    if (bus.stall_cycles !== 16'd1) begin
      errors++; $display("FAIL jr_perf: got %0d expected 1", bus.stall_cycles);
    end
    clr_inputs();
    bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd0;
    bus.ID_PCSrc = PCSRC_JR; bus.ID_Rs = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL jr_r0: got %b expected %b", outs, NORM);
    end
    next_cycle();
    // branch reading a load result sitting in MEM
    clr_inputs();
    bus.MEM_MemRead = 1'b1; bus.MEM_WriteReg = 5'd2;
    bus.ID_Branch = 1'b1; bus.ID_Rs = 5'd1; bus.ID_Rt = 5'd2;
    @(negedge clk);
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL br_mem: got %b expected %b", outs, STALL);
    end
    next_cycle();
    bus.MEM_MemRead = 1'b0; bus.MEM_WriteReg = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL br_mem_rel: got %b expected %b", outs, NORM);
    end
    next_cycle();
    clr_inputs();
  endtask

  task automatic test_mem_freeze();
    start_test();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd1;
    bus.ID_Branch = 1'b1; bus.ID_Rs = 5'd1; bus.ID_Rt = 5'd2; bus.ID_Taken = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL mf_first: got %b expected %b", outs, STALL);
    end
    next_cycle();
    bus.MEM_MemReq = 1'b1; bus.MEM_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== FRZ) begin
        errors++; $display("FAIL mf_frz%0d: got %b expected %b", i, outs, FRZ);
      end
      next_cycle();
    end
    bus.MEM_Ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== STALL) begin
      errors++; $display("FAIL mf_tail: got %b expected %b", outs, STALL);
    end
    next_cycle();
    bus.EX_MemRead = 1'b0; bus.EX_RegWrite = 1'b0; bus.EX_WriteReg = 5'd0;
    bus.MEM_MemReq = 1'b0; bus.MEM_Ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== NORM_TK) begin
      errors++; $display("FAIL mf_run: got %b expected %b", outs, NORM_TK);
    end
    next_cycle();
    checks++;
    if (bus.stall_cycles !== 16'd5) begin
      errors++; $display("FAIL mf_perf: got %0d expected 5", bus.stall_cycles);
    end
    clr_inputs();
  endtask

  task automatic test_reset_mid();
    start_test();
    // reset during HAZ
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd1;
    bus.ID_Branch = 1'b1; bus.ID_Rs = 5'd1;
    next_cycle();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL rm_haz_perf: got %0d expected 0", bus.stall_cycles);
    end
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL rm_haz_outs: got %b expected %b", outs, NORM);
    end
    next_cycle();
    reset = 1'b0;
    clr_inputs();
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL rm_haz_abort: got %b expected %b", outs, NORM);
    end
    next_cycle();
    // reset during MEMWAIT
    bus.MEM_MemReq = 1'b1;
    next_cycle();
    next_cycle();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL rm_mw_perf: got %0d expected 0", bus.stall_cycles);
    end
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL rm_mw_outs: got %b expected %b", outs, NORM);
    end
    next_cycle();
    reset = 1'b0;
    clr_inputs();
    @(negedge clk);
    checks++;
    if (outs !== NORM) begin
      errors++; $display("FAIL rm_mw_run: got %b expected %b", outs, NORM);
    end
    next_cycle();
  endtask

  task automatic test_saturate();
    start_test();
    bus.EX_MemRead = 1'b1; bus.EX_RegWrite = 1'b1; bus.EX_WriteReg = 5'd1;
    bus.ID_Rs = 5'd1;
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (bus.stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach: got %0h expected ffff", bus.stall_cycles);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: got %0h expected ffff", bus.stall_cycles);
    end
    bus.perf_clear = 1'b1;
    next_cycle();
    checks++;
    if (bus.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL clr_prio: got %0d expected 0", bus.stall_cycles);
    end
    bus.perf_clear = 1'b0;
    next_cycle();
    checks++;
    if (bus.stall_cycles !== 16'd1) begin
      errors++; $display("FAIL clr_resume: got %0d expected 1", bus.stall_cycles);
    end
    clr_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_load();
    test_jr();
    test_mem_freeze();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
